// File: rtl/psum_layer_seq_if.sv
// Partial-sum layer sequencer stream bundle: partial-sum beats in, requantised pixels out.
// Ports: in_valid/in_ready/in_psum carry lane-packed signed partial sums (lane 0 at LSBs);
//        out_valid/out_ready/out_data/out_last carry requantised lanes with end-of-layer marker.
interface psum_layer_seq_if #(
  parameter int FILTER_NUM = 32,
  parameter int PEA_NUM    = 4,
  parameter int IN_W       = 16,
  parameter int OUT_W      = 8
);
  localparam int LANES = FILTER_NUM * PEA_NUM;

  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*IN_W-1:0]  in_psum;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*OUT_W-1:0] out_data;
  logic                   out_last;

  // slave: the sequencer itself; master: upstream CCM source plus downstream writer
  modport slave (
    input  in_valid, in_psum, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

  modport master (
    output in_valid, in_psum, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/psum_layer_seq.sv
// Sequences one conv layer (pass innermost, then column, then row group), accumulates
// per-pixel partial sums across passes and requantises (round, shift, ReLU, saturate).
// Ports: clk/rst (sync, active-high); start + cfg_* latched in IDLE; busy/done status;
//        bus = psum_layer_seq_if.slave (partial-sum input stream, 1-cycle-latency output register).
module psum_layer_seq #(
  parameter int FILTER_NUM = 32,
  parameter int PEA_NUM    = 4,
  parameter int IN_W       = 16,
  parameter int ACC_W      = 24,
  parameter int OUT_W      = 8,
  parameter int DIM_W      = 9,
  parameter int PASS_W     = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DIM_W-1:0]  cfg_col,
  input  logic [DIM_W-1:0]  cfg_rowgrp,
  input  logic [PASS_W-1:0] cfg_passes,
  input  logic [4:0]        cfg_shift,
  input  logic              cfg_relu,
  output logic              busy,
  output logic              done,
  psum_layer_seq_if.slave   bus
);

  localparam int LANES = FILTER_NUM * PEA_NUM;
  localparam logic signed [ACC_W:0] OMAX = (ACC_W+1)'((1 << (OUT_W-1)) - 1);
  localparam logic signed [ACC_W:0] OMIN = -OMAX - 1;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t state_q, state_d;

  logic [DIM_W-1:0]  col_q, rowgrp_q, col_cnt, rg_cnt;
  logic [PASS_W-1:0] passes_q, pass_cnt;
  logic [4:0]        shift_q;
  logic              relu_q;
  logic              zero_done_q;
  logic              out_valid_q, out_last_q;
  logic [LANES*OUT_W-1:0] out_data_q, q_data;

  logic signed [ACC_W-1:0] acc_q   [LANES];
  logic signed [ACC_W-1:0] acc_nxt [LANES];

  logic cfg_zero, final_pass, final_col, final_rg, last_beat, beat_fire, start_ok;

  function automatic logic signed [ACC_W-1:0] sext(input logic signed [IN_W-1:0] x);
    return ACC_W'(x);
  endfunction

  // Add one guard bit; a disagreement between the top two bits means overflow.
  function automatic logic signed [ACC_W-1:0] sat_add(input logic signed [ACC_W-1:0] a,
                                                      input logic signed [ACC_W-1:0] b);
    logic [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    if (s[ACC_W] != s[ACC_W-1])
      sat_add = s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    else
      sat_add = s[ACC_W-1:0];
  endfunction

  // Round-half-up then arithmetic shift, carried out one bit wider than the accumulator.
  function automatic logic [OUT_W-1:0] requant(input logic signed [ACC_W-1:0] sum,
                                               input logic [4:0] sh, input logic relu);
    logic signed [ACC_W:0] t, rnd;
    rnd = '0;
    if (sh != 5'd0) rnd = (ACC_W+1)'(1) << (sh - 5'd1);
    t = {sum[ACC_W-1], sum} + rnd;
    t = t >>> sh;
    if (relu && t[ACC_W]) t = '0;
    if (t > OMAX)      requant = OMAX[OUT_W-1:0];
    else if (t < OMIN) requant = OMIN[OUT_W-1:0];
    else               requant = t[OUT_W-1:0];
  endfunction

  assign cfg_zero   = (cfg_col == '0) || (cfg_rowgrp == '0) || (cfg_passes == '0);
  assign start_ok   = (state_q == IDLE) && start && !cfg_zero;
  assign final_pass = (pass_cnt == passes_q - 1'b1);
  assign final_col  = (col_cnt == col_q - 1'b1);
  assign final_rg   = (rg_cnt == rowgrp_q - 1'b1);
  assign last_beat  = final_pass && final_col && final_rg;

  // Only pixel-completing beats need a free output slot; earlier passes never stall.
  assign bus.in_ready = (state_q == RUN) && (!final_pass || !out_valid_q || bus.out_ready);
  assign beat_fire    = bus.in_valid && bus.in_ready;

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign busy          = (state_q == RUN) || (state_q == FLUSH);
  assign done          = (state_q == DONE) || zero_done_q;

  // Lane datapath: on pass 0 the accumulator restarts from the beat itself, so with a
  // single pass the requantised sum is simply the input.
  always_comb begin
    q_data = '0;
    for (int i = 0; i < LANES; i++) begin
      acc_nxt[i] = (pass_cnt == '0) ? sext(bus.in_psum[i*IN_W +: IN_W])
                                    : sat_add(acc_q[i], sext(bus.in_psum[i*IN_W +: IN_W]));
      q_data[i*OUT_W +: OUT_W] = requant(acc_nxt[i], shift_q, relu_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = RUN;
      RUN:     if (beat_fire && last_beat) state_d = FLUSH;
      FLUSH:   if (out_valid_q && bus.out_ready && out_last_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q       <= '0;
      rowgrp_q    <= '0;
      passes_q    <= '0;
      shift_q     <= '0;
      relu_q      <= 1'b0;
      col_cnt     <= '0;
      rg_cnt      <= '0;
      pass_cnt    <= '0;
      zero_done_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      for (int i = 0; i < LANES; i++) acc_q[i] <= '0;
    end else begin
      zero_done_q <= (state_q == IDLE) && start && cfg_zero;

      if (start_ok) begin
        col_q    <= cfg_col;
        rowgrp_q <= cfg_rowgrp;
        passes_q <= cfg_passes;
        shift_q  <= cfg_shift;
        relu_q   <= cfg_relu;
        col_cnt  <= '0;
        rg_cnt   <= '0;
        pass_cnt <= '0;
      end

      if (beat_fire) begin
        for (int i = 0; i < LANES; i++) acc_q[i] <= acc_nxt[i];
        if (final_pass) begin
          pass_cnt <= '0;
          if (final_col) begin
            col_cnt <= '0;
            rg_cnt  <= final_rg ? '0 : rg_cnt + 1'b1;
          end else begin
            col_cnt <= col_cnt + 1'b1;
          end
        end else begin
          pass_cnt <= pass_cnt + 1'b1;
        end
      end

      // A completing pixel always has a free slot here (in_ready guaranteed it), so it
      // may overwrite a word that is handshaking in this same cycle.
      if (beat_fire && final_pass) begin
        out_valid_q <= 1'b1;
        out_data_q  <= q_data;
        out_last_q  <= last_beat;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_psum_layer_seq.sv
// Bench for psum_layer_seq: directed and randomised layers against a queue-based reference model.
// Ports: none; drives the default-sized DUT plus a 2-lane ACC_W=16 instance for accumulator clamping.
module tb_psum_layer_seq;
  localparam int FN = 32, PN = 4, IW = 16, AW = 24, OW = 8, DW = 9, PW = 6;
  localparam int NL = FN * PN;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, s_start;
  logic [DW-1:0] cfg_col, cfg_rowgrp;
  logic [PW-1:0] cfg_passes;
  logic [4:0]    cfg_shift;
  logic          cfg_relu;
  logic busy, done, s_busy, s_done;

  psum_layer_seq_if #(.FILTER_NUM(FN), .PEA_NUM(PN), .IN_W(IW), .OUT_W(OW)) bus ();
  psum_layer_seq_if #(.FILTER_NUM(2), .PEA_NUM(1), .IN_W(IW), .OUT_W(OW)) sbus ();

  psum_layer_seq #(.FILTER_NUM(FN), .PEA_NUM(PN), .IN_W(IW), .ACC_W(AW), .OUT_W(OW),
                   .DIM_W(DW), .PASS_W(PW)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_col(cfg_col), .cfg_rowgrp(cfg_rowgrp),
    .cfg_passes(cfg_passes), .cfg_shift(cfg_shift), .cfg_relu(cfg_relu),
    .busy(busy), .done(done), .bus(bus));

  psum_layer_seq #(.FILTER_NUM(2), .PEA_NUM(1), .IN_W(IW), .ACC_W(16), .OUT_W(OW),
                   .DIM_W(DW), .PASS_W(PW)) dut_sat (
    .clk(clk), .rst(rst), .start(s_start), .cfg_col(cfg_col), .cfg_rowgrp(cfg_rowgrp),
    .cfg_passes(cfg_passes), .cfg_shift(cfg_shift), .cfg_relu(cfg_relu),
    .busy(s_busy), .done(s_done), .bus(sbus));

  typedef struct {
    logic [NL*OW-1:0] d;
    logic             last;
  } exp_t;

  logic [NL*IW-1:0] beats[$];
  exp_t exp_q[$];
  exp_t got_q[$];
  exp_t mon_e;

  int vectors = 0, miscompares = 0, done_cnt = 0;
  int ready_mode = 1;
  bit gap_en = 0;
  bit prev_stall = 0;
  logic [NL*OW-1:0] prev_data;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_data(string name, logic [NL*OW-1:0] act, logic [NL*OW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      for (int l = 0; l < NL; l++)
        if (act[l*OW +: OW] !== exp[l*OW +: OW]) begin
          $display("FAIL %s: lane %0d got %0h expected %0h", name, l, act[l*OW +: OW], exp[l*OW +: OW]);
          break;
        end
    end
  endtask

  // ---------------- reference model ----------------
  function automatic longint clampw(longint v, int w);
    longint hi, lo;
    hi = (longint'(1) << (w - 1)) - 1;
    lo = -(longint'(1) << (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic logic [OW-1:0] requant_m(longint s, int sh, bit relu);
    longint t;
    logic [63:0] tv;
    t = s + ((sh > 0) ? (longint'(1) << (sh - 1)) : 0);
    t = t >>> sh;
    if (relu && t < 0) t = 0;
    t = clampw(t, OW);
    tv = t;
    return tv[OW-1:0];
  endfunction

  function automatic logic [NL*IW-1:0] mk_beat(int v0, int v1, int vr);
    logic [NL*IW-1:0] b;
    for (int l = 0; l < NL; l++) b[l*IW +: IW] = IW'((l == 0) ? v0 : (l == 1) ? v1 : vr);
    return b;
  endfunction

  function automatic logic [NL*IW-1:0] rand_beat();
    logic [NL*IW-1:0] b;
    for (int l = 0; l < NL; l++) b[l*IW +: IW] = IW'($urandom);
    return b;
  endfunction

  // Expected pixel stream for the whole layer held in beats[] (pass-major per pixel).
  task automatic build_expected(int col, int rg, int ps, int sh, bit relu);
    int np = col * rg;
    for (int p = 0; p < np; p++) begin
      exp_t e;
      for (int l = 0; l < NL; l++) begin
        longint s = 0;
        for (int k = 0; k < ps; k++) begin
          logic [NL*IW-1:0] bb;
          logic signed [IW-1:0] x;
          bb = beats[p*ps + k];
          x  = bb[l*IW +: IW];
          s  = (k == 0) ? longint'(x) : clampw(s + longint'(x), AW);
        end
        e.d[l*OW +: OW] = requant_m(s, sh, relu);
      end
      e.last = (p == np - 1);
      exp_q.push_back(e);
    end
  endtask

  // ---------------- drivers ----------------
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       bus.out_ready = 1'b0;
      1:       bus.out_ready = 1'b1;
      default: bus.out_ready = ($urandom_range(0, 1) == 1);
    endcase
  end

  task automatic do_start(int col, int rg, int ps, int sh, bit relu);
    cfg_col = DW'(col); cfg_rowgrp = DW'(rg); cfg_passes = PW'(ps);
    cfg_shift = 5'(sh); cfg_relu = relu;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drive_beats(int nmax);
    int i = 0, guard = 0;
    while (i < nmax && guard < 5000) begin
      bus.in_valid = gap_en ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.in_psum  = beats[i];
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) i++;
      @(posedge clk); #1;
      guard++;
    end
    bus.in_valid = 1'b0;
    if (guard >= 5000) chk("drive_timeout", 64'(i), 64'(nmax));
  endtask

  task automatic finish_layer(int dc);
    int g = 0;
    while (done_cnt == dc && g < 4000) begin
      @(negedge clk);
      g++;
    end
    chk("done_seen", 64'(done_cnt != dc), 64'd1);
    chk("exp_drained", 64'(exp_q.size()), 64'd0);
    repeat (3) @(negedge clk);
    chk("done_once", 64'(done_cnt - dc), 64'd1);
    @(posedge clk); #1;
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 64'(bus.out_valid), 64'd1);
        chk_data("hold_data", bus.out_data, prev_data);
      end
      if (bus.out_valid && bus.out_ready) begin
        mon_e.d = bus.out_data;
        mon_e.last = bus.out_last;
        got_q.push_back(mon_e);
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 64'd1, 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk_data("out_data", bus.out_data, mon_e.d);
          chk("out_last", 64'(bus.out_last), 64'(mon_e.last));
        end
      end
      if (done) begin
        done_cnt++;
        chk("done_before_drain", 64'(exp_q.size()), 64'd0);
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int dc, g;
    logic [NL*OW-1:0] d;
    rst = 1'b1; start = 1'b0; s_start = 1'b0;
    cfg_col = '0; cfg_rowgrp = '0; cfg_passes = '0; cfg_shift = '0; cfg_relu = 1'b0;
    bus.in_valid = 1'b0; bus.in_psum = '0; bus.out_ready = 1'b1;
    sbus.in_valid = 1'b0; sbus.in_psum = '0; sbus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_status", {60'd0, busy, done, bus.in_ready, bus.out_valid}, 64'd0);
    chk("rst_last", 64'(bus.out_last), 64'd0);
    chk_data("rst_data", bus.out_data, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic: two single-pass pixels, lane 0 = 5 then -7.
    beats = {}; got_q = {};
    beats.push_back(mk_beat(5, 0, 0));
    beats.push_back(mk_beat(-7, 0, 0));
    build_expected(2, 1, 1, 0, 0);
    dc = done_cnt;
    do_start(2, 1, 1, 0, 0);
    drive_beats(2);
    finish_layer(dc);
    chk("basic_count", 64'(got_q.size()), 64'd2);
    if (got_q.size() == 2) begin
      d = got_q[0].d; chk("basic_px0", 64'(d[7:0]), 64'h05);
      d = got_q[1].d; chk("basic_px1", 64'(d[7:0]), 64'hF9);
      chk("basic_last", {62'd0, got_q[0].last, got_q[1].last}, 64'd1);
    end

    // Multi-pass rounding: 3 x 100 with shift 2 -> 75 on every lane, one output only.
    beats = {}; got_q = {};
    repeat (3) beats.push_back(mk_beat(100, 100, 100));
    build_expected(1, 1, 3, 2, 0);
    dc = done_cnt;
    do_start(1, 1, 3, 2, 0);
    drive_beats(3);
    finish_layer(dc);
    chk("mp_count", 64'(got_q.size()), 64'd1);
    if (got_q.size() == 1) chk_data("mp_75", got_q[0].d, {NL{8'd75}});

    // Saturation / ReLU: lane0 200+200, lane1 -150-150.
    for (int relu = 0; relu < 2; relu++) begin
      beats = {}; got_q = {};
      repeat (2) beats.push_back(mk_beat(200, -150, 0));
      build_expected(1, 1, 2, 0, relu[0]);
      dc = done_cnt;
      do_start(1, 1, 2, 0, relu[0]);
      drive_beats(2);
      finish_layer(dc);
      chk("sat_count", 64'(got_q.size()), 64'd1);
      if (got_q.size() == 1) begin
        d = got_q[0].d;
        chk("sat_pos", 64'(d[7:0]), 64'h7F);
        chk("sat_neg", 64'(d[15:8]), (relu == 0) ? 64'h80 : 64'h00);
      end
    end

    // Backpressure: out_ready low for 5 cycles with a pixel pending.
    beats = {}; got_q = {};
    repeat (4) beats.push_back(rand_beat());
    build_expected(4, 1, 1, 3, 0);
    ready_mode = 0;
    @(posedge clk); #1;
    dc = done_cnt;
    do_start(4, 1, 1, 3, 0);
    fork drive_beats(4); join_none
    g = 0;
    while (!bus.out_valid && g < 100) begin @(negedge clk); g++; end
    chk("bp_valid_seen", 64'(bus.out_valid), 64'd1);
    repeat (5) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
    end
    ready_mode = 1;
    finish_layer(dc);
    wait fork;
    chk("bp_count", 64'(got_q.size()), 64'd4);

    // Reset mid-RUN after 3 of 8 beats.
    beats = {}; got_q = {};
    repeat (8) beats.push_back(rand_beat());
    build_expected(8, 1, 1, 1, 0);
    dc = done_cnt;
    do_start(8, 1, 1, 1, 0);
    drive_beats(3);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mrst_status", {60'd0, busy, done, bus.in_ready, bus.out_valid}, 64'd0);
    chk("mrst_last", 64'(bus.out_last), 64'd0);
    chk_data("mrst_data", bus.out_data, '0);
    exp_q = {};
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("mrst_no_done", 64'(done_cnt - dc), 64'd0);
    @(posedge clk); #1;
    beats = {}; got_q = {};
    beats.push_back(rand_beat());
    build_expected(1, 1, 1, 4, 1);
    dc = done_cnt;
    do_start(1, 1, 1, 4, 1);
    drive_beats(1);
    finish_layer(dc);
    chk("mrst_fresh_count", 64'(got_q.size()), 64'd1);

    // Zero config: passes=0, then col=0.
    for (int z = 0; z < 2; z++) begin
      got_q = {};
      dc = done_cnt;
      if (z == 0) do_start(2, 1, 0, 0, 0);
      else        do_start(0, 3, 2, 0, 0);
      @(negedge clk);
      chk("zero_done", 64'(done), 64'd1);
      chk("zero_busy", 64'(busy), 64'd0);
      @(negedge clk);
      chk("zero_done_clear", 64'(done), 64'd0);
      repeat (6) begin
        @(negedge clk);
        chk("zero_no_out", {62'd0, busy, bus.out_valid}, 64'd0);
      end
      chk("zero_done_cnt", 64'(done_cnt - dc), 64'd1);
      @(posedge clk); #1;
    end

    // start while busy is ignored.
    beats = {}; got_q = {};
    repeat (6) beats.push_back(rand_beat());
    build_expected(3, 1, 2, 5, 0);
    dc = done_cnt;
    do_start(3, 1, 2, 5, 0);
    fork
      drive_beats(6);
      begin
        repeat (2) @(posedge clk);
        #2;
        cfg_col = DW'(1); cfg_passes = PW'(1); start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
      end
    join
    finish_layer(dc);
    chk("busy_start_count", 64'(got_q.size()), 64'd3);

    // Randomised layers with input gaps and random downstream backpressure.
    gap_en = 1; ready_mode = 2;
    for (int t = 0; t < 8; t++) begin
      int col = $urandom_range(1, 4), rg = $urandom_range(1, 3), ps = $urandom_range(1, 4);
      int sh = $urandom_range(0, 12);
      bit relu = $urandom_range(0, 1) == 1;
      beats = {}; got_q = {};
      repeat (col * rg * ps) beats.push_back(rand_beat());
      build_expected(col, rg, ps, sh, relu);
      dc = done_cnt;
      do_start(col, rg, ps, sh, relu);
      drive_beats(col * rg * ps);
      finish_layer(dc);
      chk("rand_count", 64'(got_q.size()), 64'(col * rg));
    end
    gap_en = 0; ready_mode = 1;

    // Narrow-accumulator instance: 32767+32767 and -32768-32768 clamp before the shift.
    cfg_col = DW'(1); cfg_rowgrp = DW'(1); cfg_passes = PW'(2); cfg_shift = 5'd9; cfg_relu = 1'b0;
    s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    sbus.in_valid = 1'b1;
    sbus.in_psum  = {16'h8000, 16'h7FFF};
    repeat (2) @(posedge clk);
    #1;
    sbus.in_valid = 1'b0;
    g = 0;
    while (!sbus.out_valid && g < 20) begin @(negedge clk); g++; end
    chk("acc16_valid", 64'(sbus.out_valid), 64'd1);
    chk("acc16_lit", 64'(sbus.out_data), 64'hC040);
    chk("acc16_model", 64'(sbus.out_data),
        64'({requant_m(clampw(-65536, 16), 9, 0), requant_m(clampw(65534, 16), 9, 0)}));
    g = 0;
    while (!s_done && g < 20) begin @(negedge clk); g++; end
    chk("acc16_done", 64'(s_done), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
